mlp_input_streamer: RTL and testbench
=====================================

Name: mlp_input_streamer

Overview:
- Producer-side front end for the MLP accelerator datapath.
- Accepts a byte stream of one input vector over a valid/ready handshake and packs it into the flat input-data bus.
- Pulses the datapath's input-register load enable and the controller start, waits for inference completion, then returns the classification index over a second valid/ready handshake.
- Sits between the host/DMA stream and the datapath/controller pair.

Parameters:
- NUM_BYTES, 62, bytes per input vector; the datapath input_data width is NUM_BYTES*8.
- BYTE_W, 8, width of one stream element.
- CNT_W, 16, width of the completed-inference counter.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- rst  in  1  reset, asynchronous, active-low.
- s_valid  in  1  stream byte valid.
- s_data  in  BYTE_W  stream byte.
- s_last  in  1  last byte of the vector.
- s_ready  out  1  streamer can accept a byte.
- input_data  out  NUM_BYTES*BYTE_W  packed vector to the datapath.
- input_en  out  1  one-cycle load strobe for the datapath input register.
- start  out  1  one-cycle inference start to the controller.
- net_done  in  1  controller pulse: model_result is valid this cycle.
- model_result  in  4  classification index from the datapath comparator.
- res_valid  out  1  result available.
- res_index  out  4  captured classification index.
- res_ready  in  1  consumer accepts the result.
- frame_err  out  1  one-cycle pulse on a malformed frame.
- infer_cnt  out  CNT_W  count of results delivered (wraps).

Behaviour:
- Reset (rst=0, asynchronous): state=FILL, byte index=0, input_data=0, and s_ready, input_en, start, res_valid, frame_err all 0. res_index=0, infer_cnt=0. s_ready rises the first cycle after reset release.
- Reset asserted mid-operation aborts any frame or inference immediately. A late net_done after reset is ignored because state is FILL.
- FILL:
  - s_ready=1.
  - On each handshake (s_valid&s_ready), byte k is written to input_data[k*8 +: 8] and k increments.
  - Byte 0 lands in the least-significant byte.
  - The frame completes when k==NUM_BYTES-1 is accepted, or when s_last is accepted earlier (short frame; see Optional Feature).
  - On completion, go to LOAD next cycle; s_ready drops the cycle after the final handshake.
- LOAD: exactly one cycle. input_en=1, start=1, s_ready=0. Then go to WAIT.
- WAIT:
  - s_ready=0; input_data is held stable.
  - On net_done=1, capture model_result into res_index and go to REPORT.
  - net_done in any other state is ignored.
- REPORT:
  - res_valid=1 and res_index is held until res_ready=1.
  - On that handshake: res_valid drops the next cycle, infer_cnt increments (wraps at 2^CNT_W), k resets to 0, and state returns to FILL.
  - s_ready stays 0 throughout REPORT. There is no overlap of the next frame with the pending result.
- Latency: last byte accepted -> input_en/start 1 cycle later. net_done -> res_valid 1 cycle later.
- Long-frame rule: s_last absent on byte NUM_BYTES-1 is not an error. The frame completes at byte NUM_BYTES-1, and subsequent bytes belong to the next frame.

Optional Feature:
- Macro: MLP_STREAM_ZERO_PAD_EN.
- Defined: s_last accepted at k<NUM_BYTES-1 completes the frame. Bytes k+1..NUM_BYTES-1 of input_data are forced to 0 in that same cycle, then LOAD proceeds normally. frame_err stays 0.
- Undefined: an early s_last pulses frame_err for one cycle, the frame is discarded (no LOAD, no start), k resets to 0, and state stays FILL. Stale bytes are not cleared; they are overwritten by the next frame.

Decomposition:
- Package mlp_stream_pkg holds:
  - state enum {FILL, LOAD, WAIT, REPORT};
  - localparams NUM_BYTES, BYTE_W, IDX_W = $clog2(NUM_BYTES), RES_W = 4.
- Sub-module byte_packer: owns the input_data register, byte-index counter, indexed byte write and optional zero-pad clear. The FSM stays in mlp_input_streamer.

Test Plan:
- Reset/idle: hold rst=0 for 3 cycles -> all outputs 0; after release, s_ready=1 and infer_cnt=0.
- Full frame: stream bytes 0x01..0x3E with s_last on byte 61 and continuous valid -> input_data[7:0]=0x01 and input_data[495:488]=0x3E. Exactly one input_en/start pulse, 1 cycle after byte 61. s_ready=0 thereafter.
- Result path: net_done with model_result=7, res_ready held low 5 cycles -> res_valid=1 and res_index=7 stable for all 5 cycles. When res_ready rises, the handshake completes, infer_cnt=1, and s_ready=1 the next cycle.
- Backpressure/gaps: random s_valid gaps during FILL, and a net_done pulse injected during FILL -> packed vector identical to the gap-free case; the spurious net_done produces no res_valid.
- Short frame: s_last on byte 9 (bytes 0xAA):
  - with MLP_STREAM_ZERO_PAD_EN, bytes 10..61 read 0 and start pulses once;
  - without it, frame_err pulses once, there is no start, and the next full frame is processed normally.
- Mid-run reset: assert rst during WAIT, then release and send a full frame -> no res_valid from the aborted run; the new run yields the correct result and infer_cnt=1.

Source files
------------

// File: rtl/mlp_stream_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mlp_stream_pkg
//  Purpose  : Shared types and constants for the MLP input streamer.
//             Holds the streamer FSM state type, the default vector geometry
//             and the width of the classification index.
//  Revision : 1.0  initial release
// ============================================================================
package mlp_stream_pkg;

  localparam int NUM_BYTES = 62;
  localparam int BYTE_W    = 8;
  localparam int IDX_W     = $clog2(NUM_BYTES);
  localparam int RES_W     = 4;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    LOAD   = 2'd1,
    WAIT   = 2'd2,
    REPORT = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/byte_packer.sv
`default_nettype none
// ============================================================================
//  Module   : byte_packer
//  Purpose  : Owns the packed input-vector register and the byte index.
//             Each accepted byte is written at the current index; the index
//             then advances and parks on the final byte position until it
//             is cleared. Optionally zeroes every byte above the current
//             index in the same cycle (short-frame padding).
//  Ports    : clk, rst (async, active-low)
//             wr_en    - write wr_data at the current index
//             wr_data  - byte to store
//             pad_en   - clear all bytes above the current index
//             clr_idx  - return the index to byte 0 (wins over advance)
//             data     - packed vector, byte 0 in the least-significant byte
//             at_last  - current index is the final byte of the vector
//  Revision : 1.0  initial release
// ============================================================================
module byte_packer #(
  parameter int NUM_BYTES = mlp_stream_pkg::NUM_BYTES,
  parameter int BYTE_W    = mlp_stream_pkg::BYTE_W,
  parameter int K_W       = $clog2(NUM_BYTES)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [BYTE_W-1:0]           wr_data,
  input  logic                        pad_en,
  input  logic                        clr_idx,
  output logic [NUM_BYTES*BYTE_W-1:0] data,
  output logic                        at_last
);
  import mlp_stream_pkg::*;

  localparam logic [K_W-1:0] LAST_IDX = K_W'(NUM_BYTES - 1);

  logic [K_W-1:0]              idx_q, idx_d;
  logic [NUM_BYTES*BYTE_W-1:0] data_q, data_d;

  assign at_last = (idx_q == LAST_IDX);
  assign data    = data_q;

  // The index holds at the last position after a full frame so it can never
  // run past the vector; the controller clears it when the result retires.
  always_comb begin
    idx_d = idx_q;
    if (clr_idx) begin
      idx_d = '0;
    end else if (wr_en && !at_last) begin
      idx_d = idx_q + K_W'(1);
    end
  end

  always_comb begin
    data_d = data_q;
    for (int j = 0; j < NUM_BYTES; j++) begin
      if (wr_en && (idx_q == K_W'(j))) begin
        data_d[j*BYTE_W +: BYTE_W] = wr_data;
      end else if (pad_en && (K_W'(j) > idx_q)) begin
        data_d[j*BYTE_W +: BYTE_W] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q  <= '0;
      data_q <= '0;
    end else begin
      idx_q  <= idx_d;
      data_q <= data_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mlp_input_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : mlp_input_streamer
//  Purpose  : Producer-side front end of the MLP accelerator. Packs one
//             input vector from a byte stream, pulses the datapath load
//             enable and the controller start, waits for net_done, then
//             offers the classification index on a valid/ready handshake.
//  Config   : MLP_STREAM_ZERO_PAD_EN - when defined, an early s_last ends
//             the frame and zero-pads the remaining bytes; when undefined,
//             an early s_last pulses frame_err and discards the frame.
//  Ports    : clk, rst (async, active-low)
//             s_valid/s_data/s_last/s_ready  - input byte stream
//             input_data, input_en           - packed vector + load strobe
//             start                          - inference start strobe
//             net_done, model_result         - inference completion + index
//             res_valid/res_index/res_ready  - result handshake
//             frame_err                      - malformed frame pulse
//             infer_cnt                      - results delivered (wraps)
//  Revision : 1.0  initial release
// ============================================================================
module mlp_input_streamer #(
  parameter int NUM_BYTES = mlp_stream_pkg::NUM_BYTES,
  parameter int BYTE_W    = mlp_stream_pkg::BYTE_W,
  parameter int CNT_W     = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             s_valid,
  input  logic [BYTE_W-1:0]                s_data,
  input  logic                             s_last,
  output logic                             s_ready,
  output logic [NUM_BYTES*BYTE_W-1:0]      input_data,
  output logic                             input_en,
  output logic                             start,
  input  logic                             net_done,
  input  logic [mlp_stream_pkg::RES_W-1:0] model_result,
  output logic                             res_valid,
  output logic [mlp_stream_pkg::RES_W-1:0] res_index,
  input  logic                             res_ready,
  output logic                             frame_err,
  output logic [CNT_W-1:0]                 infer_cnt
);
  import mlp_stream_pkg::*;

  state_e             state_q, state_d;
  logic               s_ready_q, s_ready_d;
  logic               frame_err_q, frame_err_d;
  logic [RES_W-1:0]   res_index_q, res_index_d;
  logic [CNT_W-1:0]   infer_cnt_q, infer_cnt_d;

  logic at_last;
  logic s_hs;
  logic early_last;
  logic frame_done;
  logic bad_frame;
  logic pad_en;
  logic res_hs;
  logic clr_idx;

  // s_ready is registered so it stays low while reset is asserted and only
  // rises on the first clock after release.
  assign s_hs       = s_valid && s_ready_q && (state_q == FILL);
  assign early_last = s_hs && s_last && !at_last;
  assign res_hs     = (state_q == REPORT) && res_ready;

`ifdef MLP_STREAM_ZERO_PAD_EN
  assign frame_done = s_hs && (at_last || s_last);
  assign pad_en     = early_last;
  assign bad_frame  = 1'b0;
`else
  assign frame_done = s_hs && at_last;
  assign pad_en     = 1'b0;
  assign bad_frame  = early_last;
`endif

  // A discarded frame restarts at byte 0; stale bytes are simply overwritten.
  assign clr_idx = res_hs || bad_frame;

  byte_packer #(
    .NUM_BYTES (NUM_BYTES),
    .BYTE_W    (BYTE_W)
  ) u_packer (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (s_hs),
    .wr_data (s_data),
    .pad_en  (pad_en),
    .clr_idx (clr_idx),
    .data    (input_data),
    .at_last (at_last)
  );

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (frame_done) state_d = LOAD;
      LOAD:    state_d = WAIT;
      WAIT:    if (net_done)   state_d = REPORT;
      REPORT:  if (res_ready)  state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic
  // --------------------------------------------------------------------------
  always_comb begin
    input_en    = (state_q == LOAD);
    start       = (state_q == LOAD);
    res_valid   = (state_q == REPORT);
    s_ready_d   = (state_d == FILL);
    frame_err_d = bad_frame;
    res_index_d = res_index_q;
    if ((state_q == WAIT) && net_done) begin
      res_index_d = model_result;
    end
    infer_cnt_d = infer_cnt_q;
    if (res_hs) begin
      infer_cnt_d = infer_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_ready_q   <= 1'b0;
      frame_err_q <= 1'b0;
      res_index_q <= '0;
      infer_cnt_q <= '0;
    end else begin
      s_ready_q   <= s_ready_d;
      frame_err_q <= frame_err_d;
      res_index_q <= res_index_d;
      infer_cnt_q <= infer_cnt_d;
    end
  end

  assign s_ready   = s_ready_q;
  assign frame_err = frame_err_q;
  assign res_index = res_index_q;
  assign infer_cnt = infer_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mlp_input_streamer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_mlp_input_streamer
//  Purpose  : Self-checking bench for mlp_input_streamer. A byte-array model
//             of the packed vector, a delivered-result counter and pulse
//             counters give every expected value.
//  Config   : MLP_STREAM_ZERO_PAD_EN selects the expected short-frame rule.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mlp_input_streamer;
  localparam int NB = 62;
  localparam int BW = 8;
  localparam int CW = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              s_valid = 1'b0;
  logic [BW-1:0]     s_data = '0;
  logic              s_last = 1'b0;
  logic              s_ready;
  logic [NB*BW-1:0]  input_data;
  logic              input_en;
  logic              start;
  logic              net_done = 1'b0;
  logic [3:0]        model_result = '0;
  logic              res_valid;
  logic [3:0]        res_index;
  logic              res_ready = 1'b0;
  logic              frame_err;
  logic [CW-1:0]     infer_cnt;

  always #5 clk = ~clk;

  mlp_input_streamer #(.NUM_BYTES(NB), .BYTE_W(BW), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_last       (s_last),
    .s_ready      (s_ready),
    .input_data   (input_data),
    .input_en     (input_en),
    .start        (start),
    .net_done     (net_done),
    .model_result (model_result),
    .res_valid    (res_valid),
    .res_index    (res_index),
    .res_ready    (res_ready),
    .frame_err    (frame_err),
    .infer_cnt    (infer_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Pulse counters sampled mid-cycle
  int en_seen = 0, st_seen = 0, fe_seen = 0, rv_seen = 0;
  always @(negedge clk) begin
    if (input_en)  en_seen++;
    if (start)     st_seen++;
    if (frame_err) fe_seen++;
    if (res_valid) rv_seen++;
  end

  initial begin
    repeat (50000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  logic [7:0] fb  [NB];   // bytes to send
  logic [7:0] mdl [NB];   // expected contents of input_data, byte-wise
  int         exp_cnt = 0;

  function automatic logic [NB*BW-1:0] exp_vec();
    logic [NB*BW-1:0] v;
    for (int j = 0; j < NB; j++) v[j*8 +: 8] = mdl[j];
    return v;
  endfunction

  task automatic model_write(input int n, input bit pad);
    for (int j = 0; j < NB; j++) begin
      if (j < n) mdl[j] = fb[j];
      else if (pad) mdl[j] = 8'h00;
    end
  endtask

  task automatic model_clear();
    for (int j = 0; j < NB; j++) mdl[j] = 8'h00;
    exp_cnt = 0;
  endtask

  // Sends fb[0..n-1]; returns just after the edge accepting the last one.
  task automatic send_bytes(input int n, input int last_pos, input bit gaps,
                            input int spur_at);
    int  sent = 0;
    int  cyc  = 0;
    bit  v;
    bit  acc;
    while (sent < n && cyc < 2000) begin
      v        = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      s_valid  = v;
      s_data   = v ? fb[sent] : 8'($urandom);
      s_last   = v && (sent == last_pos);
      net_done = (cyc == spur_at);
      model_result = 4'($urandom);
      acc      = v && s_ready;
      @(posedge clk); #1;
      if (acc) sent++;
      cyc++;
    end
    s_valid = 1'b0; s_last = 1'b0; net_done = 1'b0;
    if (sent < n) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: sent %0d bytes, required %0d", sent, n);
    end
  endtask

  // Entered in LOAD; completes a result handshake after `hold` stalled cycles.
  task automatic run_result(input logic [3:0] r, input int hold);
    repeat (1 + $urandom_range(0, 3)) begin @(posedge clk); #1; end
    n_cmp++;
    if (res_valid !== 1'b0) begin
      n_bad++; $display("FAIL wait_res_valid: got %b required 0", res_valid);
    end
    net_done = 1'b1; model_result = r;
    @(posedge clk); #1;
    net_done = 1'b0; model_result = ~r;
    n_cmp++;
    if (res_valid !== 1'b1 || res_index !== r) begin
      n_bad++;
      $display("FAIL result_latency: got valid=%b idx=%0d required valid=1 idx=%0d",
               res_valid, res_index, r);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (res_valid !== 1'b1 || res_index !== r || s_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL result_hold[%0d]: got valid=%b idx=%0d rdy=%b required 1/%0d/0",
                 i, res_valid, res_index, s_ready, r);
      end
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    exp_cnt++;
    n_cmp++;
    if (res_valid !== 1'b0 || infer_cnt !== CW'(exp_cnt) || s_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL result_retire: got valid=%b cnt=%0d rdy=%b required 0/%0d/1",
               res_valid, infer_cnt, s_ready, exp_cnt);
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    model_clear();
    n_cmp++;
    if ({s_ready, input_en, start, res_valid, frame_err} !== 5'b0 ||
        res_index !== 4'd0 || infer_cnt !== '0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got rdy/en/st/rv/fe=%b idx=%0d cnt=%0d required all 0",
               {s_ready, input_en, start, res_valid, frame_err}, res_index, infer_cnt);
    end
    n_cmp++;
    if (input_data !== '0) begin
      n_bad++; $display("FAIL reset_data: got %h required 0", input_data);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (s_ready !== 1'b1 || infer_cnt !== '0) begin
      n_bad++;
      $display("FAIL reset_release: got rdy=%b cnt=%0d required 1/0", s_ready, infer_cnt);
    end
  endtask

  task automatic test_full_frame();
    int en0 = en_seen, st0 = st_seen;
    for (int i = 0; i < NB; i++) fb[i] = 8'(i + 1);
    send_bytes(NB, NB - 1, 1'b0, -1);
    model_write(NB, 1'b0);
    n_cmp++;
    if (input_en !== 1'b1 || start !== 1'b1 || s_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL full_load_strobe: got en=%b st=%b rdy=%b required 1/1/0",
               input_en, start, s_ready);
    end
    n_cmp++;
    if (input_data[7:0] !== 8'h01 || input_data[495:488] !== 8'h3E) begin
      n_bad++;
      $display("FAIL full_ends: got lo=%h hi=%h required 01/3e",
               input_data[7:0], input_data[495:488]);
    end
    n_cmp++;
    if (input_data !== exp_vec()) begin
      n_bad++; $display("FAIL full_vector: got %h required %h", input_data, exp_vec());
    end
    repeat (3) begin @(posedge clk); #1; end
    n_cmp++;
    if (en_seen - en0 != 1 || st_seen - st0 != 1 || s_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL full_pulses: got en=%0d st=%0d rdy=%b required 1/1/0",
               en_seen - en0, st_seen - st0, s_ready);
    end
    // Already in WAIT; run_result's extra idle cycles keep it there.
    run_result(4'd7, 5);
  endtask

  task automatic test_gaps();
    int rv0;
    logic [3:0] prev_idx;
    logic [3:0] r;
    for (int i = 0; i < NB; i++) fb[i] = 8'($urandom);
    rv0      = rv_seen;
    prev_idx = res_index;
    send_bytes(NB, NB - 1, 1'b1, $urandom_range(3, 40));
    model_write(NB, 1'b0);
    n_cmp++;
    if (input_data !== exp_vec()) begin
      n_bad++; $display("FAIL gaps_vector: got %h required %h", input_data, exp_vec());
    end
    n_cmp++;
    if (rv_seen != rv0 || res_index !== prev_idx) begin
      n_bad++;
      $display("FAIL gaps_spurious_done: got rv=%0d idx=%0d required 0/%0d",
               rv_seen - rv0, res_index, prev_idx);
    end
    r = 4'($urandom);
    run_result(r, $urandom_range(0, 3));
  endtask

  task automatic test_short_frame();
    int en0 = en_seen, st0 = st_seen, fe0 = fe_seen;
    for (int i = 0; i < 10; i++) fb[i] = 8'hAA;
    send_bytes(10, 9, 1'b0, -1);
`ifdef MLP_STREAM_ZERO_PAD_EN
    model_write(10, 1'b1);
    n_cmp++;
    if (input_data !== exp_vec() || input_en !== 1'b1) begin
      n_bad++;
      $display("FAIL short_pad: got en=%b data=%h required en=1 data=%h",
               input_en, input_data, exp_vec());
    end
    repeat (3) begin @(posedge clk); #1; end
    n_cmp++;
    if (st_seen - st0 != 1 || fe_seen != fe0) begin
      n_bad++;
      $display("FAIL short_pad_pulses: got st=%0d fe=%0d required 1/0",
               st_seen - st0, fe_seen - fe0);
    end
    run_result(4'd3, 1);
`else
    repeat (3) begin @(posedge clk); #1; end
    n_cmp++;
    if (fe_seen - fe0 != 1 || st_seen != st0 || en_seen != en0 || s_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL short_err: got fe=%0d st=%0d en=%0d rdy=%b required 1/0/0/1",
               fe_seen - fe0, st_seen - st0, en_seen - en0, s_ready);
    end
    for (int i = 0; i < NB; i++) fb[i] = 8'($urandom);
    send_bytes(NB, NB - 1, 1'b0, -1);
    model_write(NB, 1'b0);
    n_cmp++;
    if (input_data !== exp_vec() || input_en !== 1'b1) begin
      n_bad++;
      $display("FAIL short_recover: got en=%b data=%h required en=1 data=%h",
               input_en, input_data, exp_vec());
    end
    run_result(4'd3, 1);
`endif
  endtask

  // Several frames in a row, some without s_last on the final byte.
  task automatic test_back_to_back();
    for (int f = 0; f < 4; f++) begin
      int en0 = en_seen;
      bit with_last = (f % 2 == 0);
      for (int i = 0; i < NB; i++) fb[i] = 8'($urandom);
      send_bytes(NB, with_last ? NB - 1 : -1, f > 1, -1);
      model_write(NB, 1'b0);
      n_cmp++;
      if (input_data !== exp_vec() || input_en !== 1'b1 || en_seen != en0) begin
        n_bad++;
        $display("FAIL b2b_frame[%0d]: got en=%b prior=%0d data=%h required 1/0/%h",
                 f, input_en, en_seen - en0, input_data, exp_vec());
      end
      run_result(4'($urandom), $urandom_range(0, 2));
    end
  endtask

  task automatic test_mid_reset();
    int rv0;
    for (int i = 0; i < NB; i++) fb[i] = 8'($urandom);
    send_bytes(NB, NB - 1, 1'b0, -1);
    repeat (2) begin @(posedge clk); #1; end
    rv0 = rv_seen;
    rst = 1'b0;
    net_done = 1'b1; model_result = 4'd9;
    @(posedge clk); #1;
    model_clear();
    n_cmp++;
    if (input_data !== '0 || res_valid !== 1'b0 || s_ready !== 1'b0 || infer_cnt !== '0) begin
      n_bad++;
      $display("FAIL midrst_hold: got rv=%b rdy=%b cnt=%0d data_nz=%b required 0/0/0/0",
               res_valid, s_ready, infer_cnt, input_data != '0);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    net_done = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (rv_seen != rv0 || s_ready !== 1'b1 || res_index !== 4'd0) begin
      n_bad++;
      $display("FAIL midrst_late_done: got rv=%0d rdy=%b idx=%0d required 0/1/0",
               rv_seen - rv0, s_ready, res_index);
    end
    for (int i = 0; i < NB; i++) fb[i] = 8'($urandom);
    send_bytes(NB, NB - 1, 1'b1, -1);
    model_write(NB, 1'b0);
    n_cmp++;
    if (input_data !== exp_vec()) begin
      n_bad++; $display("FAIL midrst_vector: got %h required %h", input_data, exp_vec());
    end
    run_result(4'd12, 2);
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_gaps();
    test_short_frame();
    test_back_to_back();
    test_mid_reset();
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
